// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR step function, default 7-bit tap table and search FSM states
package lfsr_pkg;

  localparam int LFSR_W   = 7;
  localparam int N_TAPS_7 = 9;

  localparam logic [LFSR_W-1:0] TAP_TABLE_7 [N_TAPS_7] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] t);
    return {s[LFSR_W-2:0], ^(t & s)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational Fibonacci LFSR next-state: shift left, parity of tapped bits enters LSB
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int W = 7
) (
  input  logic [W-1:0] i_state,
  input  logic [W-1:0] i_taps,
  output logic [W-1:0] o_next
);

  generate
    if (W == LFSR_W) begin : g_pkg
      assign o_next = lfsr_next(i_state, i_taps);
    end else begin : g_generic
      assign o_next = {i_state[W-2:0], ^(i_taps & i_state)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_tap_search.sv
// rtl/lfsr_tap_search.sv - finds the lowest-index tap pattern reproducing L keystream words, then runs as generator
module lfsr_tap_search
  import lfsr_pkg::*;
#(
  parameter int W      = 7,
  parameter int N_TAPS = 9,
  parameter int L      = 4,
  parameter logic [W-1:0] TAP_TABLE [N_TAPS] = TAP_TABLE_7
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_kin_valid,
  input  logic [W-1:0]              i_kin_data,
  output logic                      o_kin_ready,
  input  logic                      i_start,
  input  logic                      i_clear,
  input  logic                      i_adv,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_found,
  output logic [$clog2(N_TAPS)-1:0] o_match_idx,
  output logic [W-1:0]              o_match_taps,
  output logic [W-1:0]              o_state_out
);

  localparam int IW = $clog2(N_TAPS);
  localparam int CW = $clog2(L + 1);
  localparam int JW = $clog2(L);
  localparam logic [CW-1:0] L_COUNT  = CW'(L);
  localparam logic [JW-1:0] J_LAST   = JW'(L - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_TAPS - 1);

  fsm_state_t    r_fsm;
  logic [W-1:0]  r_buf [L];
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_state;
  logic [IW-1:0] r_idx;
  logic [JW-1:0] r_j;
  logic          r_found;
  logic [IW-1:0] r_match_idx;
  logic [W-1:0]  r_match_taps;
  logic [W-1:0]  r_state_out;

  logic [W-1:0]  w_step_s;
  logic [W-1:0]  w_step_t;
  logic [W-1:0]  w_next;
  logic          w_hit;
  logic          w_xfer;

  // One step unit serves both the search compare and the post-match generator.
  always_comb begin
    w_step_s = r_state;
    w_step_t = TAP_TABLE[r_idx];
    if (r_fsm == ST_DONE) begin
      w_step_s = r_state_out;
      w_step_t = r_match_taps;
    end
  end

  lfsr_step #(.W(W)) u_step (
    .i_state (w_step_s),
    .i_taps  (w_step_t),
    .o_next  (w_next)
  );

  assign w_hit       = (w_next == r_buf[r_j]);
  assign o_kin_ready = (r_fsm == ST_IDLE) && (r_count < L_COUNT);
  assign w_xfer      = i_kin_valid && o_kin_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm        <= ST_IDLE;
      for (int k = 0; k < L; k++) r_buf[k] <= '0;
      r_count      <= '0;
      r_state      <= '0;
      r_idx        <= '0;
      r_j          <= '0;
      r_found      <= 1'b0;
      r_match_idx  <= '0;
      r_match_taps <= '0;
      r_state_out  <= '0;
    end else if (i_clear) begin
      r_fsm        <= ST_IDLE;
      r_count      <= '0;
      r_found      <= 1'b0;
      r_match_idx  <= '0;
      r_match_taps <= '0;
      r_state_out  <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_xfer) begin
            r_buf[r_count[JW-1:0]] <= i_kin_data;
            r_count                <= r_count + CW'(1);
          end
          if (i_start && (r_count == L_COUNT)) begin
            r_state <= r_buf[0];
            r_idx   <= '0;
            r_j     <= JW'(1);
            r_fsm   <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (w_hit) begin
            if (r_j == J_LAST) begin
              r_found      <= 1'b1;
              r_match_idx  <= r_idx;
              r_match_taps <= TAP_TABLE[r_idx];
              r_state_out  <= w_next;
              r_fsm        <= ST_DONE;
            end else begin
              r_j     <= r_j + JW'(1);
              r_state <= w_next;
            end
          end else if (r_idx == IDX_LAST) begin
            r_found <= 1'b0;
            r_fsm   <= ST_DONE;
          end else begin
            // Restart from the seed with the next candidate in the same cycle.
            r_idx   <= r_idx + IW'(1);
            r_state <= r_buf[0];
            r_j     <= JW'(1);
          end
        end
        ST_DONE: begin
          if (i_adv && r_found) r_state_out <= w_next;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_fsm == ST_SEARCH);
  assign o_done       = (r_fsm == ST_DONE);
  assign o_found      = r_found;
  assign o_match_idx  = r_match_idx;
  assign o_match_taps = r_match_taps;
  assign o_state_out  = r_state_out;

endmodule
